// File: rtl/uart_rx_pkg.sv
// uart_rx shared definitions: receiver states and bit-timing helpers.
// Imported by the receiver top and reusable by the matching transmitter.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   localparam int CNT_W = 11;

   function automatic int clocks_per_bit(
      input int clk_hz,
      input int baud
   );
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input.
// Both flops reset to RST_VAL so the line looks idle out of reset.
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a valid/ready byte output, framing-error
// and overrun pulses. Timing mirrors uart_tx for lossless loopback.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int BAUD_RATE = 9600,
   parameter int CLOCK_MHZ = 10_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid_o,
   input  logic       data_ready,
   output logic       frame_err_o,
   output logic       overrun_o
);

   localparam int CPB  = clocks_per_bit(CLOCK_MHZ, BAUD_RATE);
   localparam int HALF = CPB / 2;

   localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CPB - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

   logic             w_rx_s;
   logic             w_hs;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shreg;

   uart_sync2 #(
      .RST_VAL(1'b1)
   ) u_sync (
      .i_clk  (clk),
      .i_rst_n(rst),
      .i_d    (rx),
      .o_q    (w_rx_s)
   );

   assign w_hs = data_valid_o && data_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_bit_idx    <= '0;
         r_shreg      <= '0;
         data_out     <= '0;
         data_valid_o <= 1'b0;
         frame_err_o  <= 1'b0;
         overrun_o    <= 1'b0;
      end else begin
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
         if (w_hs) data_valid_o <= 1'b0;

         unique case (r_state)
            S_IDLE: begin
               r_cnt     <= '0;
               r_bit_idx <= '0;
               if (!w_rx_s) r_state <= S_START;
            end
            S_START: begin
               if (r_cnt == CNT_HALF) begin
                  r_cnt   <= '0;
                  r_state <= w_rx_s ? S_IDLE : S_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (r_cnt == CNT_BIT) begin
                  r_cnt     <= '0;
                  r_shreg   <= {w_rx_s, r_shreg[7:1]};
                  r_bit_idx <= r_bit_idx + 1'b1;
                  if (r_bit_idx == 3'd7) r_state <= S_STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (r_cnt == CNT_BIT) begin
                  r_cnt <= '0;
                  if (w_rx_s) begin
                     r_state <= S_IDLE;
                     // a same-cycle handshake frees the holding register
                     if (!data_valid_o || data_ready) begin
                        data_out     <= r_shreg;
                        data_valid_o <= 1'b1;
                     end else begin
                        overrun_o <= 1'b1;
                     end
                  end else begin
                     frame_err_o <= 1'b1;
                     r_state     <= S_BREAK;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_BREAK: begin
               if (w_rx_s) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 10 clocks per bit.
// Bytes are queued when driven and compared on each handshake.
module tb_uart_rx;

   localparam int BAUD = 1_000_000;
   localparam int CLKHZ = 10_000_000;
   localparam int CPB = CLKHZ / BAUD;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx = 1'b1;
   logic       data_ready = 1'b0;
   logic [7:0] data_out;
   logic       data_valid_o;
   logic       frame_err_o;
   logic       overrun_o;

   int n_chk = 0;
   int n_err = 0;
   int n_ferr = 0;
   int n_ovr = 0;
   int n_rx = 0;
   int n_push = 0;
   logic [7:0] sb[$];

   uart_rx #(
      .BAUD_RATE(BAUD),
      .CLOCK_MHZ(CLKHZ)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .data_out    (data_out),
      .data_valid_o(data_valid_o),
      .data_ready  (data_ready),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o)
   );

   always #5 clk = ~clk;

   task automatic check(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      idle(CPB);
   endtask

   task automatic send_frame(
      input logic [7:0] b,
      input logic       stop
   );
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
   endtask

   task automatic push(input logic [7:0] b);
      sb.push_back(b);
      n_push++;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (frame_err_o) n_ferr++;
         if (overrun_o) n_ovr++;
         if (data_valid_o && data_ready) begin
            if (sb.size() == 0) begin
               check("rx_unexpected", 32'd1, 32'd0);
            end else begin
               check("rx_byte", 32'(data_out),
                     32'(sb.pop_front()));
               n_rx++;
            end
         end
      end
   end

   initial begin
      int f0;
      int o0;
      logic [7:0] b;

      rst = 1'b0;
      idle(3);
      check("rst_valid", 32'(data_valid_o), 32'd0);
      check("rst_data", 32'(data_out), 32'd0);
      check("rst_ferr", 32'(frame_err_o), 32'd0);
      check("rst_ovr", 32'(overrun_o), 32'd0);
      rst = 1'b1;
      idle(5);

      // held byte, consumer not ready
      push(8'hA5);
      send_frame(8'hA5, 1'b1);
      idle(20);
      check("hold_valid", 32'(data_valid_o), 32'd1);
      check("hold_data", 32'(data_out), 32'hA5);
      idle(30);
      check("hold_data2", 32'(data_out), 32'hA5);
      data_ready = 1'b1;
      idle(1);
      check("hs_clear", 32'(data_valid_o), 32'd0);

      // short start glitch
      f0 = n_ferr;
      rx = 1'b0;
      idle(3);
      rx = 1'b1;
      idle(30);
      check("glitch_valid", 32'(data_valid_o), 32'd0);
      check("glitch_ferr", 32'(n_ferr - f0), 32'd0);

      // bad stop bit then line held low
      f0 = n_ferr;
      send_frame(8'h3C, 1'b0);
      idle(50);
      rx = 1'b1;
      idle(20);
      check("break_ferr", 32'(n_ferr - f0), 32'd1);
      check("break_valid", 32'(data_valid_o), 32'd0);
      push(8'h11);
      send_frame(8'h11, 1'b1);
      idle(20);
      check("after_break", 32'(sb.size()), 32'd0);

      // overrun
      data_ready = 1'b0;
      o0 = n_ovr;
      push(8'h00);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(20);
      check("ovr_pulse", 32'(n_ovr - o0), 32'd1);
      check("ovr_data", 32'(data_out), 32'h00);
      check("ovr_valid", 32'(data_valid_o), 32'd1);
      data_ready = 1'b1;
      idle(2);
      check("ovr_drop", 32'(data_valid_o), 32'd0);

      // back-to-back frames
      f0 = n_ferr;
      o0 = n_ovr;
      push(8'h55);
      push(8'hAA);
      send_frame(8'h55, 1'b1);
      send_frame(8'hAA, 1'b1);
      idle(20);
      check("b2b_drain", 32'(sb.size()), 32'd0);
      check("b2b_ferr", 32'(n_ferr - f0), 32'd0);
      check("b2b_ovr", 32'(n_ovr - o0), 32'd0);

      // reset during bit 4
      data_ready = 1'b0;
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      rx = 1'b1;
      idle(3);
      rst = 1'b0;
      #1;
      check("mid_rst_valid", 32'(data_valid_o), 32'd0);
      check("mid_rst_data", 32'(data_out), 32'd0);
      check("mid_rst_ferr", 32'(frame_err_o), 32'd0);
      check("mid_rst_ovr", 32'(overrun_o), 32'd0);
      idle(5);
      rst = 1'b1;
      f0 = n_ferr;
      o0 = n_ovr;
      idle(20);
      check("post_rst_ferr", 32'(n_ferr - f0), 32'd0);
      check("post_rst_valid", 32'(data_valid_o), 32'd0);
      data_ready = 1'b1;
      push(8'h7E);
      send_frame(8'h7E, 1'b1);
      idle(20);
      check("post_rst_rx", 32'(sb.size()), 32'd0);

      // loopback of random bytes
      f0 = n_ferr;
      o0 = n_ovr;
      for (int i = 0; i < 256; i++) begin
         b = 8'($urandom_range(0, 255));
         push(b);
         send_frame(b, 1'b1);
      end
      idle(20);
      check("lb_ferr", 32'(n_ferr - f0), 32'd0);
      check("lb_ovr", 32'(n_ovr - o0), 32'd0);
      check("lb_drain", 32'(sb.size()), 32'd0);
      check("rx_count", 32'(n_rx), 32'(n_push));

      $display("Result: errors=%0d of %0d checks",
               n_err, n_chk);
      $finish;
   end

endmodule
